// File: rtl/writeback_pipe_if.sv
// Handshake bundle for the write-back stage: upstream entry bus plus the
// register-file write port. master = producer/consumer side, slave = the stage.
interface writeback_pipe_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic [DATA_W-1:0] in_mem_data;
   logic              in_sel_mem;
   logic              in_ld_byte;
   logic              in_byte_hi;
   logic              in_ld_signed;
   logic              in_we;
   logic [ADDR_W-1:0] in_rd_addr;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;
   logic              rf_ready;

   modport master (
      output in_valid, in_result, in_mem_data, in_sel_mem, in_ld_byte,
             in_byte_hi, in_ld_signed, in_we, in_rd_addr, rf_ready,
      input  in_ready, rf_we, rf_addr, rf_wdata
   );

   modport slave (
      input  in_valid, in_result, in_mem_data, in_sel_mem, in_ld_byte,
             in_byte_hi, in_ld_signed, in_we, in_rd_addr, rf_ready,
      output in_ready, rf_we, rf_addr, rf_wdata
   );
endinterface

// File: rtl/writeback_pipe.sv
// Write-back stage: result/load select, byte extract+extend, 2-entry skid buffer.
// Optional macro WB_FWD_EN adds a combinational lookup over buffered writes.
module writeback_pipe #(
   parameter int DATA_W        = 16,
   parameter int ADDR_W        = 4,
   parameter int ZERO_REG_DROP = 1,
   parameter int COUNT_W       = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   writeback_pipe_if.slave    bus,
   output logic [COUNT_W-1:0] retire_count
`ifdef WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0]  fwd_qaddr,
   output logic               fwd_hit,
   output logic [DATA_W-1:0]  fwd_data
`endif
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   logic [1:0] occ;
   entry_t     head_q;
   entry_t     tail_q;
   entry_t     new_entry;
   logic [7:0] ld_byte;
   logic       head_valid;
   logic       accept;
   logic       retire;

   // Write data is fixed at accept time so a stalled entry never re-reads upstream.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      new_entry = '0;
      ld_byte   = bus.in_byte_hi ? bus.in_mem_data[15:8] : bus.in_mem_data[7:0];
      if (!bus.in_sel_mem)
         new_entry.data = bus.in_result;
      else if (!bus.in_ld_byte)
         new_entry.data = bus.in_mem_data;
      else
         new_entry.data = {{(DATA_W-8){bus.in_ld_signed & ld_byte[7]}}, ld_byte};
      new_entry.addr = bus.in_rd_addr;
      new_entry.we   = bus.in_we &&
                       !((ZERO_REG_DROP != 0) && (bus.in_rd_addr == '0));
   end

   assign head_valid   = (occ != EMPTY);
   assign bus.in_ready = (occ != FULL);
   assign accept       = bus.in_valid && bus.in_ready && !flush;
   assign retire       = head_valid && !flush && (bus.rf_ready || !head_q.we);

   assign bus.rf_we    = head_valid && head_q.we && !flush;
   assign bus.rf_addr  = head_valid ? head_q.addr : '0;
   assign bus.rf_wdata = head_valid ? head_q.data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ          <= EMPTY;
         // NOTE: the two slots are only a few flops, so they are reset too; this
         // keeps rf_addr/rf_wdata free of X even though they are gated by head_valid.
         head_q       <= '0;
         tail_q       <= '0;
         retire_count <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all slots update together.
         if (retire)
            retire_count <= retire_count + COUNT_W'(1);
         if (flush) begin
            occ <= EMPTY;
         end else begin
            case (occ)
               EMPTY: begin
                  if (accept) begin
                     head_q <= new_entry;
                     occ    <= ONE;
                  end
               end
               ONE: begin
                  if (accept && retire) begin
                     head_q <= new_entry;
                  end else if (accept) begin
                     tail_q <= new_entry;
                     occ    <= FULL;
                  end else if (retire) begin
                     occ    <= EMPTY;
                  end
               end
               FULL: begin
                  // in_ready is low here, so only a retire can occur.
                  if (retire) begin
                     head_q <= tail_q;
                     occ    <= ONE;
                  end
               end
               default: occ <= EMPTY;
            endcase
         end
      end
   end

`ifdef WB_FWD_EN
   // The tail slot is younger than the head, so it is checked first.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (!flush) begin
         if ((occ == FULL) && tail_q.we && (tail_q.addr == fwd_qaddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = tail_q.data;
         end else if (head_valid && head_q.we && (head_q.addr == fwd_qaddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = head_q.data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_writeback_pipe.sv
// Scoreboard bench for writeback_pipe: expected writes are queued at accept
// and compared in order when the register-file write strobe fires.
module tb_writeback_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] retire_count;
`ifdef WB_FWD_EN
   logic [3:0]  fwd_qaddr = '0;
   logic        fwd_hit;
   logic [15:0] fwd_data;
`endif

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          exp_retire = 0;
   int          last_stall = 0;
   logic [19:0] sb[$];
   int          acc_cyc[$];
   int          wr_cyc[$];

   writeback_pipe_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   writeback_pipe #(
      .DATA_W(16), .ADDR_W(4), .ZERO_REG_DROP(1), .COUNT_W(16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .bus          (bus),
      .retire_count (retire_count)
`ifdef WB_FWD_EN
      ,
      .fwd_qaddr    (fwd_qaddr),
      .fwd_hit      (fwd_hit),
      .fwd_data     (fwd_data)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Every committed write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      logic [19:0] e;
      if (rst_n && bus.rf_we && bus.rf_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("wr_addr", 32'(bus.rf_addr), 32'(e[19:16]));
            check("wr_data", 32'(bus.rf_wdata), 32'(e[15:0]));
            wr_cyc.push_back(cyc);
         end
      end
   end

   // Called and returns at posedge+1; holds the entry until it is accepted.
   task automatic send(input logic [15:0] res, input logic [15:0] mem,
                       input logic sel, input logic lb, input logic hi,
                       input logic sgn, input logic we, input logic [3:0] addr,
                       input logic [15:0] exp_d);
      int n = 0;
      bus.in_result    = res;
      bus.in_mem_data  = mem;
      bus.in_sel_mem   = sel;
      bus.in_ld_byte   = lb;
      bus.in_byte_hi   = hi;
      bus.in_ld_signed = sgn;
      bus.in_we        = we;
      bus.in_rd_addr   = addr;
      bus.in_valid     = 1'b1;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      last_stall = n;
      if (n >= 50) begin
         check("send_timeout", 32'd0, 32'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (we && addr != 4'd0) sb.push_back({addr, exp_d});
      acc_cyc.push_back(cyc);
      exp_retire++;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 100) check("drain_timeout", 32'(sb.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_result = '0; bus.in_mem_data = '0;
      bus.in_sel_mem = 1'b0; bus.in_ld_byte = 1'b0; bus.in_byte_hi = 1'b0;
      bus.in_ld_signed = 1'b0; bus.in_we = 1'b0; bus.in_rd_addr = '0;
      bus.rf_ready = 1'b1;

      #3;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_rf_we", 32'(bus.rf_we), 32'd0);
      check("rst_rf_addr", 32'(bus.rf_addr), 32'd0);
      check("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
      check("rst_retire", 32'(retire_count), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back ALU results, latency and throughput
      acc_cyc.delete(); wr_cyc.delete();
      send(16'h1234, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h1234);
      send(16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'hBEEF);
      check("b2b_no_stall", 32'(last_stall), 32'd0);
      drain();
      check("b2b_writes", 32'(wr_cyc.size()), 32'd2);
      check("b2b_lat_first", 32'(wr_cyc[0]), 32'(acc_cyc[0]));
      check("b2b_lat_second", 32'(wr_cyc[1]), 32'(acc_cyc[0] + 1));
      check("b2b_retire", 32'(retire_count), 32'd2);

      // Byte and word loads from 0x80F0
      send(16'h0, 16'h80F0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 16'hFF80);
      send(16'h0, 16'h80F0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd6, 16'h0080);
      check("ld_no_stall", 32'(last_stall), 32'd0);
      send(16'h0, 16'h80F0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 16'hFFF0);
      send(16'h0, 16'h80F0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 16'h00F0);
      send(16'h0, 16'h80F0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 16'h80F0);
      drain();
      check("ld_retire", 32'(retire_count), 32'(exp_retire));

      // Back-pressure: two accepted, third held until rf_ready rises
      bus.rf_ready = 1'b0;
      send(16'h0A01, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0A01);
      send(16'h0B02, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h0B02);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_head_addr", 32'(bus.rf_addr), 32'd1);
      check("bp_head_we", 32'(bus.rf_we), 32'd1);
      fork
         send(16'h0C03, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'h0C03);
         begin
            repeat (4) @(posedge clk);
            #2;
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_retire", 32'(retire_count), 32'(exp_retire - 2));
            bus.rf_ready = 1'b1;
         end
      join
      drain();
      check("bp_retire", 32'(retire_count), 32'(exp_retire));

      // Write to r0 is suppressed but still retires without rf_ready
      bus.rf_ready = 1'b0;
      send(16'h5555, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h5555);
      @(negedge clk);
      check("r0_rf_we", 32'(bus.rf_we), 32'd0);
      @(posedge clk); #1;
      check("r0_retire", 32'(retire_count), 32'(exp_retire));
      check("r0_empty", 32'(bus.in_ready), 32'd1);

      // Flush with buffer FULL and an entry offered
      send(16'h0D0D, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 16'h0D0D);
      send(16'h0E0E, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 16'h0E0E);
      bus.in_result = 16'h0F0F; bus.in_rd_addr = 4'd6; bus.in_we = 1'b1;
      bus.in_sel_mem = 1'b0; bus.in_valid = 1'b1;
      flush = 1'b1;
`ifdef WB_FWD_EN
      fwd_qaddr = 4'd4;
      #1;
      check("fwd_flush_hit", 32'(fwd_hit), 32'd0);
`endif
      @(negedge clk);
      check("flush_rf_we", 32'(bus.rf_we), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      exp_retire -= 2;
      check("flush_empty", 32'(bus.in_ready), 32'd1);
      check("flush_rf_addr", 32'(bus.rf_addr), 32'd0);
      check("flush_rf_wdata", 32'(bus.rf_wdata), 32'd0);
      bus.rf_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("flush_retire", 32'(retire_count), 32'(exp_retire));

      // Flush with buffer EMPTY drops the incoming entry
      bus.rf_ready = 1'b0;
      bus.in_rd_addr = 4'd7; bus.in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("flush_drop_we", 32'(bus.rf_we), 32'd0);
      check("flush_drop_ready", 32'(bus.in_ready), 32'd1);
      bus.rf_ready = 1'b1;

`ifdef WB_FWD_EN
      // Forwarding: youngest match wins
      @(posedge clk); #1;
      bus.rf_ready = 1'b0;
      send(16'h0011, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h0011);
      send(16'h0022, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h0022);
      fwd_qaddr = 4'd2;
      #1;
      check("fwd_hit", 32'(fwd_hit), 32'd1);
      check("fwd_data", 32'(fwd_data), 32'h0022);
      fwd_qaddr = 4'd3;
      #1;
      check("fwd_miss_hit", 32'(fwd_hit), 32'd0);
      check("fwd_miss_data", 32'(fwd_data), 32'd0);
      bus.rf_ready = 1'b1;
      drain();
      check("fwd_retire", 32'(retire_count), 32'(exp_retire));
`endif

      // Asynchronous reset with entries buffered
      @(posedge clk); #1;
      bus.rf_ready = 1'b0;
      send(16'h0707, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h0707);
      send(16'h0808, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 16'h0808);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 32'(bus.in_ready), 32'd1);
      check("arst_rf_we", 32'(bus.rf_we), 32'd0);
      check("arst_rf_addr", 32'(bus.rf_addr), 32'd0);
      check("arst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
      check("arst_retire", 32'(retire_count), 32'd0);
      sb.delete();
      exp_retire = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.rf_ready = 1'b1;
      send(16'h7777, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 16'h7777);
      drain();
      check("post_rst_retire", 32'(retire_count), 32'(exp_retire));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_pipe.md
# writeback_pipe

Parametrised write-back stage for the pipelined RISC CPU. It sits between the memory stage and the register file. It selects the ALU result or the load data, and extracts and extends load bytes. Accepted results are held in a 2-entry skid buffer with valid/ready handshaking, so register-file back-pressure or a pipeline flush never loses or duplicates a write.

## Interface
Parameters:
- DATA_W, 16, datapath width; even, ≥16
- ADDR_W, 4, register address width
- ZERO_REG_DROP, 1, when 1, writes to register 0 are suppressed
- COUNT_W, 16, retire counter width

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- flush  in  1  discard all buffered and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_result  in  DATA_W  ALU result
- in_mem_data  in  DATA_W  load data
- in_sel_mem  in  1  1 selects load data, 0 selects the ALU result
- in_ld_byte  in  1  byte load; valid only with in_sel_mem
- in_byte_hi  in  1  byte lane: 0 = [7:0], 1 = [15:8]
- in_ld_signed  in  1  sign-extend the byte; otherwise zero-extend
- in_we  in  1  entry writes the register file
- in_rd_addr  in  ADDR_W  destination register
- rf_we  out  1  register-file write strobe
- rf_addr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- rf_ready  in  1  register file accepts the write this cycle
- retire_count  out  COUNT_W  count of retired entries

## Operation
- Write data is formed at accept time:
  - in_sel_mem=0 → in_result.
  - in_sel_mem=1, in_ld_byte=0 → in_mem_data.
  - in_sel_mem=1, in_ld_byte=1 → selected byte, extended to DATA_W. Zero-fill, or replicate bit 7 of the byte when in_ld_signed.
- If ZERO_REG_DROP=1 and in_rd_addr==0, the stored we is forced to 0.
- Buffer: 2 entries {we, addr, data}, FIFO order. Occupancy states are EMPTY, ONE and FULL.
- Accept occurs on in_valid && in_ready && !flush. in_ready = (occupancy != FULL); it depends only on registered state.
- Head output: rf_we = head_valid && head_we && !flush. rf_addr and rf_wdata always show the head entry (0 when empty).
- Retire occurs on head_valid && !flush && (rf_ready || !head_we). Entries with we=0 retire without waiting for rf_ready.
- Simultaneous accept and retire: occupancy is unchanged and order is preserved (EMPTY→ONE→FULL→ONE→EMPTY transitions only).
- Flush: at the next edge occupancy goes to EMPTY; an incoming entry that cycle is dropped. rf_we is 0 in the flush cycle, so no partial commit occurs.
- retire_count increments by 1 per retire. It wraps modulo 2^COUNT_W and is not cleared by flush.

## Timing
- Reset (async assert, sync-released by the system): occupancy EMPTY, in_ready=1, rf_we=0, rf_addr=0, rf_wdata=0, retire_count=0.
- Latency: an entry accepted at edge N drives rf_* during cycle N+1 when the buffer was empty. It waits behind the older entry otherwise.
- Throughput: 1 entry/cycle with rf_ready held high. in_ready never drops in that case.
- rf_ready low with the buffer FULL → in_ready=0 from the next cycle. Upstream must hold its data.
- Reset mid-operation: all entries are lost immediately and outputs return to their reset values asynchronously.

## Configuration
- Macro WB_FWD_EN.
- Defined: adds the ports fwd_qaddr (in, ADDR_W), fwd_hit (out, 1) and fwd_data (out, DATA_W). These perform a combinational lookup over buffered entries with we=1 and addr==fwd_qaddr. The youngest match wins. fwd_hit=0 and fwd_data=0 on a miss or during flush.
- Not defined: the ports are absent and no lookup logic is built.

## Test plan
- Back-to-back accepts, rf_ready=1, in_sel_mem=0, results 0x1234→r3 and 0xBEEF→r5. Required: rf writes in consecutive cycles starting one cycle after the first accept; retire_count=2.
- Byte loads with in_mem_data=0x80F0:
  - hi, signed → 0xFF80.
  - hi, unsigned → 0x0080.
  - lo, signed → 0xFFF0.
- rf_ready=0 while 3 entries are offered. Required: in_ready=0 after 2 accepts; the third is held. Raising rf_ready drains all 3 in order with no loss.
- Write to r0 with ZERO_REG_DROP=1. Required: rf_we stays 0, but the entry still retires (retire_count increments).
- Flush with the buffer FULL and in_valid=1. Required: rf_we=0 that cycle; EMPTY next cycle; the dropped entries are never written; retire_count is unchanged.
- With WB_FWD_EN, 0x0011→r2 then 0x0022→r2 are buffered while rf_ready=0, and fwd_qaddr=2. Required: fwd_hit=1, fwd_data=0x0022.
